bmp_stream_out: RTL and testbench

Streams the processed BMP image (54-byte header plus pixel bytes) out of the shared dual-port BMP RAM as a byte-serial valid/ready stream. Starts on a `start` pulse, normally tied to the binarization block's `done`, and reads RAM through one port at one byte per cycle. It absorbs downstream backpressure with a 2-entry output buffer. It is the synthesizable read-out that replaces the bench's direct dump of RAM contents.

---
 rtl/bmp_stream_out_pkg.sv | 16 +
 rtl/bmp_stream_out_if.sv | 28 ++
 rtl/bmp_byte_fifo2.sv | 60 ++++++
 rtl/bmp_stream_out.sv | 130 +++++++++++++
 tb/tb_bmp_stream_out.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmp_stream_out_pkg.sv
// Shared definitions for the BMP read-out streamer: parameter defaults
// (image geometry) and the controller state encoding.
package bmp_stream_out_pkg;

    // Defaults describe a 512x512 24-bit BMP with its 54-byte header.
    localparam int DEF_BYTE_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_TOTAL_SIZE = 512 * 512 * 3 + 54;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_e;

endpackage

// File: rtl/bmp_stream_out_if.sv
// RAM read port plus byte-serial valid/ready stream used by the streamer.
// master = the streamer, slave = RAM model / downstream consumer.
interface bmp_stream_out_if
    import bmp_stream_out_pkg::*;
#(
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  RAM_ren;
    logic [ADDR_WIDTH-1:0] RAM_addr;
    logic [BYTE_WIDTH-1:0] RAM_out;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [BYTE_WIDTH-1:0] tx_data;
    logic                  tx_last;

    modport master (
        output RAM_ren, RAM_addr, tx_valid, tx_data, tx_last,
        input  RAM_out, tx_ready
    );

    modport slave (
        input  RAM_ren, RAM_addr, tx_valid, tx_data, tx_last,
        output RAM_out, tx_ready
    );

endinterface

// File: rtl/bmp_byte_fifo2.sv
// Two-entry byte FIFO that soaks up downstream backpressure. The caller
// guarantees no push into a full FIFO (unless popping) and no pop when empty.
module bmp_byte_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Next-state of storage, pointers and occupancy from push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Register state; clear empties the FIFO and zeroes the storage.
    always_ff @(posedge clk) begin
        if (clear) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bmp_stream_out.sv
// Streams TOTAL_SIZE bytes of the BMP RAM, address 0 upward, as a valid/ready
// byte stream. Reads are issued only when a buffer slot is guaranteed, so the
// 2-entry FIFO can never overflow no matter how tx_ready behaves.
module bmp_stream_out
    import bmp_stream_out_pkg::*;
#(
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TOTAL_SIZE = DEF_TOTAL_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    bmp_stream_out_if.master        bus,
    output logic                    busy,
    output logic                    done
);

    // Read pointer carries one extra bit so it can reach TOTAL_SIZE itself.
    localparam logic [ADDR_WIDTH:0]   TOTAL    = (ADDR_WIDTH+1)'(TOTAL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_SIZE - 1);

    stream_state_e         state_q, state_d;
    logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start_run;
    logic                  fifo_clear;
    logic                  fifo_push;
    logic                  pop;
    logic                  credit_ok;
    logic                  ren;
    logic                  tx_valid;
    logic                  tx_last;
    logic [1:0]            fifo_count;
    logic [BYTE_WIDTH-1:0] fifo_head;

    bmp_byte_fifo2 #(
        .WIDTH (BYTE_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (pop),
        .din   (bus.RAM_out),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Handshake, read-issue credit and FIFO control for the current cycle.
    always_comb begin
        start_run  = (state_q == ST_IDLE) && start;
        fifo_clear = rst || start_run;
        tx_valid   = (fifo_count != 2'd0);
        tx_last    = tx_valid && (idx_q == LAST_IDX);
        pop        = tx_valid && bus.tx_ready;
        // count + inflight - pop < 2, rearranged to stay unsigned
        credit_ok  = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        ren        = (state_q == ST_STREAM) && (rd_addr_q < TOTAL) && credit_ok;
        fifo_push  = (state_q == ST_STREAM) && inflight_q;
    end

    // Controller next state: pointer, byte index, in-flight flag, outputs.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        idx_d      = idx_q;
        inflight_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_STREAM;
                    rd_addr_d = '0;
                    idx_d     = '0;
                end
            end
            ST_STREAM: begin
                inflight_d = ren;
                if (ren) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
                if (pop) begin
                    idx_d = idx_q + 1'b1;
                    if (tx_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_STREAM);
        done_d = (state_d == ST_DONE);
    end

    // Single state register for the FSM and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.RAM_ren  = ren;
    assign bus.RAM_addr = ren ? rd_addr_q[ADDR_WIDTH-1:0] : '0;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_valid ? fifo_head : '0;
    assign bus.tx_last  = tx_last;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bmp_stream_out.sv
// Directed bench for bmp_stream_out with an 8-byte image held in a synchronous
// RAM model (mem[i] = A0+i). Expected bytes are queued when a run is started
// and consumed by a negedge monitor as the stream hands them over.
module tb_bmp_stream_out;

    localparam int BW    = 8;
    localparam int AW    = 4;
    localparam int TOTAL = 8;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    logic [BW-1:0] mem [16];
    exp_t          exp_q [$];

    int checks     = 0;
    int errors     = 0;
    int issued_n   = 0;
    int accepted_n = 0;
    int done_total = 0;
    logic          stall_prev = 1'b0;
    logic [BW-1:0] held_data  = '0;
    logic          held_last  = 1'b0;

    bmp_stream_out_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    bmp_stream_out #(
        .BYTE_WIDTH (BW),
        .ADDR_WIDTH (AW),
        .TOTAL_SIZE (TOTAL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Synchronous RAM: data appears one cycle after a sampled read enable.
    always @(posedge clk) begin
        if (bus.RAM_ren) bus.RAM_out <= mem[bus.RAM_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; when a run is expected, queue its bytes.
    task automatic applyStimulus(input bit expect_run);
        exp_t e;
        start = 1'b1;
        if (expect_run) begin
            for (int i = 0; i < TOTAL; i++) begin
                e.data = BW'(8'hA0 + i);
                e.last = (i == TOTAL - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count cycles (continuing from 'from') until done is seen, bounded.
    task automatic waitDone(input int from, input int budget, output int at);
        at = from;
        while (done !== 1'b1 && at < budget) begin
            @(posedge clk);
            #1;
            at++;
        end
        checkOutput("done_seen", done, 1'b1);
    endtask

    // Wait until the given byte is at the stream head, bounded.
    task automatic waitHead(input logic [BW-1:0] want, input int budget);
        int n = 0;
        while (!(bus.tx_valid === 1'b1 && bus.tx_data === want) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("head_reached", {bus.tx_valid, bus.tx_data}, {1'b1, want});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {bus.RAM_ren, bus.RAM_addr, bus.tx_valid, bus.tx_data, bus.tx_last, busy, done}, '0);
    endtask

    // Monitor: scoreboard on every handshake, hold-while-stalled, credit bound.
    always @(negedge clk) begin
        if (rst) begin
            issued_n   <= 0;
            accepted_n <= 0;
            stall_prev <= 1'b0;
        end else begin
            checkOutput("outstanding_le_2", ((issued_n - accepted_n) <= 2), 1);
            if (stall_prev && bus.tx_valid) begin
                checkOutput("stall_data_stable", bus.tx_data, held_data);
                checkOutput("stall_last_stable", bus.tx_last, held_last);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", bus.tx_data, 'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("tx_data", bus.tx_data, e.data);
                    checkOutput("tx_last", bus.tx_last, e.last);
                end
            end
            issued_n   <= issued_n + int'(bus.RAM_ren);
            accepted_n <= accepted_n + int'(bus.tx_valid && bus.tx_ready);
            stall_prev <= bus.tx_valid && !bus.tx_ready;
            held_data  <= bus.tx_data;
            held_last  <= bus.tx_last;
        end
        if (done) done_total <= done_total + 1;
    end

    // Directed sequence of scenarios.
    initial begin
        int at;
        int base;
        bit got_done;
        bit ren_seen;

        for (int i = 0; i < 16; i++) mem[i] = BW'(8'hA0 + i);
        bus.tx_ready = 1'b0;

        // Reset held two cycles with start asserted alongside it.
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_outputs");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("start_with_rst_ignored", {busy, bus.RAM_ren, bus.tx_valid}, 3'b000);

        // Full-rate run.
        bus.tx_ready = 1'b1;
        base = done_total;
        applyStimulus(1);
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("ren_after_start", bus.RAM_ren, 1'b1);
        checkOutput("addr0_after_start", bus.RAM_addr, 0);
        checkOutput("no_valid_e0", bus.tx_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("no_valid_e1", bus.tx_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("first_byte_e2", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA0});
        waitDone(2, 40, at);
        checkOutput("done_latency", at, 10);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", {done, busy}, 2'b00);
        checkOutput("run1_done_count", done_total - base, 1);
        checkOutput("run1_queue_empty", exp_q.size(), 0);

        // Alternating ready.
        repeat (2) @(posedge clk);
        #1;
        base = done_total;
        applyStimulus(1);
        got_done = 1'b0;
        for (int c = 0; c < 80 && !got_done; c++) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1'b1;
            bus.tx_ready = ~bus.tx_ready;
        end
        checkOutput("toggle_done", got_done, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("toggle_done_count", done_total - base, 1);
        checkOutput("toggle_queue_empty", exp_q.size(), 0);

        // Long stall with A3 at the head.
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        base = done_total;
        applyStimulus(1);
        waitHead(8'hA3, 20);
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_head_a3", {bus.RAM_ren, bus.tx_valid, bus.tx_data}, {1'b0, 1'b1, 8'hA3});
        ren_seen = 1'b0;
        repeat (17) begin
            @(posedge clk);
            #1;
            ren_seen |= bus.RAM_ren;
        end
        checkOutput("stall_no_reads", ren_seen, 1'b0);
        bus.tx_ready = 1'b1;
        waitDone(0, 40, at);
        @(posedge clk);
        #1;
        checkOutput("stall_done_count", done_total - base, 1);
        checkOutput("stall_queue_empty", exp_q.size(), 0);

        // Start re-pulsed mid-stream is ignored; a later start reruns.
        repeat (2) @(posedge clk);
        #1;
        base = done_total;
        applyStimulus(1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0);
        waitDone(4, 40, at);
        checkOutput("restart_ignored_latency", at, 10);
        @(posedge clk);
        #1;
        checkOutput("restart_done_count", done_total - base, 1);
        checkOutput("restart_queue_empty", exp_q.size(), 0);
        applyStimulus(1);
        waitDone(0, 40, at);
        checkOutput("second_run_latency", at, 10);
        @(posedge clk);
        #1;
        checkOutput("second_run_queue_empty", exp_q.size(), 0);

        // Reset right after A4 is accepted aborts; next start begins at A0.
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1);
        waitHead(8'hA4, 20);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("abort_outputs");
        exp_q.delete();
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        base = done_total;
        applyStimulus(1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("after_abort_first", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA0});
        waitDone(2, 40, at);
        checkOutput("after_abort_latency", at, 10);
        @(posedge clk);
        #1;
        checkOutput("after_abort_done_count", done_total - base, 1);
        checkOutput("after_abort_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the sequence itself stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
